// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and default widths shared by the ALU writeback stage and its
// head/skid buffer.
//   DEF_DATA_W     datapath width (must match the ALU)
//   DEF_RF_ADDR_W  register-file address width
//   wb_state_e     buffer occupancy: empty, head only, head + skid
//   wb_entry_t     one pending register write {addr, data}
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_RF_ADDR_W = 3;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_ONE   = 2'd1,
        WB_FULL  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [DEF_RF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_skid.sv
// ---------------------------------------------------------------------------
// alu_wb_skid
// Two-entry writeback buffer: a registered head that drives the register-file
// write port, plus a skid entry that absorbs one more write while the head is
// stalled. FIFO order is preserved.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   flush          discard every buffered entry
//   enq            push {enq_addr, enq_data} this cycle
//   wb_ready       register file takes the head this cycle
//   wb_valid       head holds a pending write (decoded from the state flop)
//   wb_addr/data   head entry (registered)
//   full           both entries occupied; upstream must stall
// ---------------------------------------------------------------------------
module alu_wb_skid
    import alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     enq,
    input  logic [DEF_RF_ADDR_W-1:0] enq_addr,
    input  logic [DEF_DATA_W-1:0]    enq_data,
    input  logic                     wb_ready,
    output logic                     wb_valid,
    output logic [DEF_RF_ADDR_W-1:0] wb_addr,
    output logic [DEF_DATA_W-1:0]    wb_data,
    output logic                     full
);

    wb_state_e state, state_nxt;
    wb_entry_t head, head_nxt;
    wb_entry_t skid, skid_nxt;
    wb_entry_t enq_entry;
    logic      drain;

    assign enq_entry = '{addr: enq_addr, data: enq_data};
    assign wb_valid  = (state != WB_EMPTY);
    assign full      = (state == WB_FULL);
    assign wb_addr   = head.addr;
    assign wb_data   = head.data;
    assign drain     = wb_valid & wb_ready;

    // NOTE: every signal written here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        if (flush) begin
            // A drain in this cycle still lands at the register file; the
            // entry is simply forgotten along with everything else.
            state_nxt = WB_EMPTY;
        end else begin
            unique case (state)
                WB_EMPTY: begin
                    if (enq) begin
                        state_nxt = WB_ONE;
                        head_nxt  = enq_entry;
                    end
                end
                WB_ONE: begin
                    if (enq && drain) begin
                        head_nxt  = enq_entry;
                    end else if (enq) begin
                        state_nxt = WB_FULL;
                        skid_nxt  = enq_entry;
                    end else if (drain) begin
                        state_nxt = WB_EMPTY;
                    end
                end
                WB_FULL: begin
                    // Upstream is stalled here, so only a drain can move us.
                    if (drain) begin
                        state_nxt = WB_ONE;
                        head_nxt  = skid;
                    end
                end
                default: state_nxt = WB_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= WB_EMPTY;
            head  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
        end
    end

    // NOTE: the skid entry is plain storage and is not reset; it is only
    // read in WB_FULL, which is reachable only after it has been written.
    always_ff @(posedge clk) begin
        skid <= skid_nxt;
    end

endmodule

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
// Downstream stage of the 8-bit ALU. Captures each accepted op, buffers up to
// two register writes toward the register file (valid/ready), and owns the
// architectural carry flag that feeds back as the ALU carry-in.
// Optional feature: define ALU_WB_ZFLAG_EN to add a zero_flag output that
// tracks (in_result == 0) under the same update condition as carry_flag.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   flush           drop all buffered writebacks (branch redirect)
//   in_valid/ready  ALU handshake; in_ready is combinational
//   in_result       ALU result, passed bit-exact
//   in_carry        ALU carry/shift-out bit
//   in_rd           destination register
//   in_wr_en        op writes a register (0: flag-only op)
//   in_flag_en      op updates the carry (and zero) flag
//   wb_valid/ready  register-file write handshake
//   wb_addr/data    head write (registered, stable while stalled)
//   carry_flag      architectural carry
//   zero_flag       architectural zero (ALU_WB_ZFLAG_EN only)
// DATA_W / RF_ADDR_W must stay equal to the alu_pkg defaults.
// ---------------------------------------------------------------------------
module alu_writeback
    import alu_pkg::*;
#(
    parameter int RF_ADDR_W = DEF_RF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_result,
    input  logic                 in_carry,
    input  logic [RF_ADDR_W-1:0] in_rd,
    input  logic                 in_wr_en,
    input  logic                 in_flag_en,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [RF_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 carry_flag
`ifdef ALU_WB_ZFLAG_EN
    ,
    output logic                 zero_flag
`endif
);

    logic full;
    logic accept;
    logic flag_upd;

    assign in_ready = ~full & ~flush;
    assign accept   = in_valid & in_ready;
    assign flag_upd = accept & in_flag_en;

    alu_wb_skid u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .enq      (accept & in_wr_en),
        .enq_addr (in_rd),
        .enq_data (in_result),
        .wb_ready (wb_ready),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .full     (full)
    );

    // Flags update on the same edge as the enqueue, whether or not the op
    // writes a register. flush blocks accept, so flags hold through it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry_flag <= 1'b0;
        end else if (flag_upd) begin
            carry_flag <= in_carry;
        end
    end

`ifdef ALU_WB_ZFLAG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zero_flag <= 1'b0;
        end else if (flag_upd) begin
            zero_flag <= (in_result == '0);
        end
    end
`endif

endmodule
